// File: rtl/inflate_pkg.sv
// Shared constants, state encoding and field helpers for the dynamic-block
// Huffman tree build controller.
package inflate_pkg;

  localparam int unsigned ADDR_W          = 9;
  localparam int unsigned CL_NUM          = 19;
  localparam int unsigned LL_MIN          = 257;
  localparam int unsigned MAX_HLIT_FIELD  = 29;
  localparam int unsigned MAX_HDIST_FIELD = 29;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CL,
    S_BUILD_CL,
    S_WAIT_LL,
    S_BUILD_LL,
    S_BUILD_DIST,
    S_ERR
  } hbc_state_t;

  function automatic logic [ADDR_W-1:0] ll_count(input logic [4:0] hlit);
    return ADDR_W'(hlit) + ADDR_W'(LL_MIN);
  endfunction

  function automatic logic fields_legal(input logic [4:0] hlit, input logic [4:0] hdist);
    return (32'(hlit) <= MAX_HLIT_FIELD) && (32'(hdist) <= MAX_HDIST_FIELD);
  endfunction

endpackage

// File: rtl/hufftree_build_ctrl_watchdog.sv
// Per-build cycle watchdog: synchronous clear, counts while enabled and
// flags the last permitted cycle of a build.
module hbc_watchdog #(
  parameter int unsigned WDOG_CYCLES = 4096,
  parameter int unsigned WDOG_W      = 13
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [WDOG_W-1:0] r_cnt;
  logic              w_at_limit;

  assign w_at_limit = (r_cnt == WDOG_W'(WDOG_CYCLES - 1));
  assign o_tc       = i_en && w_at_limit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_at_limit) begin
      r_cnt <= r_cnt + WDOG_W'(1);
    end
  end

endmodule

// File: rtl/hufftree_build_ctrl.sv
// Sequences the shared Huffman table generator through the CL, LL and DIST
// builds of a DEFLATE dynamic block and routes its table-write strobe.
module hufftree_build_ctrl
  import inflate_pkg::*;
#(
  parameter int unsigned CL_BASE     = 320,
  parameter int unsigned LL_BASE     = 0,
  parameter int unsigned WDOG_CYCLES = 4096,
  parameter int unsigned WDOG_W      = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [4:0] hlit,
  input  logic [4:0] hdist,
  input  logic       cl_lens_ready,
  input  logic       ll_lens_ready,
  output logic       gen_inc,
  output logic [8:0] gen_tree_num,
  output logic [8:0] gen_addr_bias,
  input  logic       gen_done,
  input  logic       gen_winc,
  output logic       cl_we,
  output logic       ll_we,
  output logic       dist_we,
  output logic       cl_valid,
  output logic       ll_valid,
  output logic       dist_valid,
  output logic       busy,
  output logic       done,
  output logic       err
);

  hbc_state_t        r_state;
  logic [4:0]        r_hlit;
  logic [4:0]        r_hdist;
  logic              r_gen_inc;
  logic [ADDR_W-1:0] r_gen_tree_num;
  logic [ADDR_W-1:0] r_gen_addr_bias;
  logic              r_cl_valid;
  logic              r_ll_valid;
  logic              r_dist_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic w_gen_done_ok;
  logic w_in_build;
  logic w_enter_build;
  logic w_wd_tc;

  // A completion on the launch cycle itself cannot be genuine.
  assign w_gen_done_ok = gen_done && !r_gen_inc;
  assign w_in_build    = (r_state == S_BUILD_CL) || (r_state == S_BUILD_LL) ||
                         (r_state == S_BUILD_DIST);

  always_comb begin
    w_enter_build = 1'b0;
    if (!abort) begin
      w_enter_build = ((r_state == S_WAIT_CL) && cl_lens_ready) ||
                      ((r_state == S_WAIT_LL) && ll_lens_ready) ||
                      ((r_state == S_BUILD_LL) && w_gen_done_ok);
    end
  end

  hbc_watchdog #(
    .WDOG_CYCLES (WDOG_CYCLES),
    .WDOG_W      (WDOG_W)
  ) u_watchdog (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clr   (w_enter_build),
    .i_en    (w_in_build),
    .o_tc    (w_wd_tc)
  );

  assign cl_we   = gen_winc && (r_state == S_BUILD_CL);
  assign ll_we   = gen_winc && (r_state == S_BUILD_LL);
  assign dist_we = gen_winc && (r_state == S_BUILD_DIST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_hlit          <= '0;
      r_hdist         <= '0;
      r_gen_inc       <= 1'b0;
      r_gen_tree_num  <= '0;
      r_gen_addr_bias <= '0;
      r_cl_valid      <= 1'b0;
      r_ll_valid      <= 1'b0;
      r_dist_valid    <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_gen_inc <= 1'b0;
      r_done    <= 1'b0;
      if (abort) begin
        r_state      <= S_IDLE;
        r_busy       <= 1'b0;
        r_err        <= 1'b0;
        r_cl_valid   <= 1'b0;
        r_ll_valid   <= 1'b0;
        r_dist_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_ERR: begin
            if (start) begin
              r_hlit       <= hlit;
              r_hdist      <= hdist;
              r_cl_valid   <= 1'b0;
              r_ll_valid   <= 1'b0;
              r_dist_valid <= 1'b0;
              r_busy       <= 1'b1;
              if (fields_legal(hlit, hdist)) begin
                r_state <= S_WAIT_CL;
                r_err   <= 1'b0;
              end else begin
                r_state <= S_ERR;
                r_err   <= 1'b1;
              end
            end
          end
          S_WAIT_CL: begin
            if (cl_lens_ready) begin
              r_state         <= S_BUILD_CL;
              r_gen_inc       <= 1'b1;
              r_gen_tree_num  <= ADDR_W'(CL_NUM);
              r_gen_addr_bias <= ADDR_W'(CL_BASE);
            end
          end
          S_BUILD_CL: begin
            if (w_gen_done_ok) begin
              r_cl_valid <= 1'b1;
              r_state    <= S_WAIT_LL;
            end else if (w_wd_tc) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
          S_WAIT_LL: begin
            if (ll_lens_ready) begin
              r_state         <= S_BUILD_LL;
              r_gen_inc       <= 1'b1;
              r_gen_tree_num  <= ll_count(r_hlit);
              r_gen_addr_bias <= ADDR_W'(LL_BASE);
            end
          end
          S_BUILD_LL: begin
            if (w_gen_done_ok) begin
              r_ll_valid      <= 1'b1;
              r_state         <= S_BUILD_DIST;
              r_gen_inc       <= 1'b1;
              r_gen_tree_num  <= ADDR_W'(r_hdist) + ADDR_W'(1);
              r_gen_addr_bias <= ADDR_W'(LL_BASE) + ll_count(r_hlit);
            end else if (w_wd_tc) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
          S_BUILD_DIST: begin
            if (w_gen_done_ok) begin
              r_dist_valid <= 1'b1;
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= S_IDLE;
            end else if (w_wd_tc) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign gen_inc       = r_gen_inc;
  assign gen_tree_num  = r_gen_tree_num;
  assign gen_addr_bias = r_gen_addr_bias;
  assign cl_valid      = r_cl_valid;
  assign ll_valid      = r_ll_valid;
  assign dist_valid    = r_dist_valid;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;

endmodule

// File: doc/hufftree_build_ctrl.md
Name: hufftree_build_ctrl

Overview:
- Sequences the single shared Huffman table generator through the three builds of a DEFLATE dynamic block: code-length (CL) tree, literal/length (LL) tree, distance (DIST) tree.
- Supplies the generator with table size and length-buffer base address, and launches each build.
- Steers the generator's table-write strobe to the correct table.
- Sits between the block-header parser / code-length decoder and the generator; the decoders consume the tree-valid flags.

Parameters:
- CL_BASE, 320: buffer base address of the 19 permuted CL code lengths.
- LL_BASE, 0: buffer base address of LL lengths; DIST lengths follow contiguously.
- WDOG_CYCLES, 4096: maximum cycles allowed per build before error.
- WDOG_W, 13: watchdog counter width; must satisfy 2^WDOG_W > WDOG_CYCLES.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: begin a dynamic block; samples hlit/hdist.
- abort  in  1  pulse: cancel any activity.
- hlit  in  5  HLIT field; LL count = hlit+257.
- hdist  in  5  HDIST field; DIST count = hdist+1.
- cl_lens_ready  in  1  pulse: CL lengths are present at CL_BASE.
- ll_lens_ready  in  1  pulse: LL+DIST lengths are present at LL_BASE.
- gen_inc  out  1  one-cycle launch pulse to the generator.
- gen_tree_num  out  9  entry count of the current tree.
- gen_addr_bias  out  9  buffer base of the current tree.
- gen_done  in  1  pulse from the generator: build complete.
- gen_winc  in  1  generator table-write strobe.
- cl_we, ll_we, dist_we  out  1 each  routed write strobes.
- cl_valid, ll_valid, dist_valid  out  1 each  level: table built.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse: all three tables valid.
- err  out  1  level; cleared by start or abort.

Behaviour:
- Reset: all outputs 0, state IDLE, watchdog 0.
- All outputs are registered except the *_we strobes.
- *_we are combinational: gen_winc AND (state == the matching BUILD state). Zero latency. gen_winc is dropped in every other state.
- States: IDLE, WAIT_CL, BUILD_CL, WAIT_LL, BUILD_LL, BUILD_DIST, ERR.
- IDLE:
  - start accepted → latch hlit/hdist.
  - Clear err and all *_valid.
  - If hlit>29 or hdist>29 → ERR; else → WAIT_CL.
- WAIT_CL: cl_lens_ready → BUILD_CL.
- BUILD_CL:
  - Registered values: gen_tree_num=19, gen_addr_bias=CL_BASE.
  - gen_inc is high on the first cycle in the state only.
  - gen_done → set cl_valid, go to WAIT_LL.
- WAIT_LL: ll_lens_ready → BUILD_LL.
- BUILD_LL:
  - gen_tree_num=hlit+257, gen_addr_bias=LL_BASE.
  - gen_done → set ll_valid, go to BUILD_DIST.
- BUILD_DIST:
  - gen_tree_num=hdist+1, gen_addr_bias=LL_BASE+hlit+257, computed 9-bit with no overflow for legal fields.
  - gen_done → set dist_valid, pulse done, go to IDLE.
- Every BUILD state:
  - gen_inc pulses on entry only.
  - gen_tree_num/gen_addr_bias are stable from the gen_inc cycle until gen_done.
  - gen_done on the same cycle as gen_inc is ignored; a build takes at least 2 cycles.
- Watchdog:
  - Counts cycles in a BUILD state; clears on entry to each BUILD state.
  - Reaching WDOG_CYCLES without gen_done → ERR.
- ERR:
  - err=1, busy=1.
  - Leaves only on abort (→ IDLE, err cleared) or start (re-evaluated as in IDLE).
- abort, in any state: → IDLE next cycle; clear all *_valid and err; no done.
  - abort and start on the same cycle: abort wins, start is dropped.
  - abort during a build: gen_inc is not re-asserted. The generator is assumed to return to idle on its own; the controller ignores any further gen_done or gen_winc.
- start while in any non-IDLE/non-ERR state is ignored.
- Ready and done pulses outside their waiting state are ignored (not remembered).
- valid flags persist after done until the next accepted start or abort.
- Reset mid-operation: immediate return to reset values.

Decomposition:
- Shared package (inflate_pkg):
  - state encoding localparams;
  - CL_NUM=19, LL_MIN=257, MAX_HLIT_FIELD=29, MAX_HDIST_FIELD=29;
  - buffer address width 9.
- One sub-module: hbc_watchdog (loadable clear, terminal-count flag).
- All remaining logic lives in the top FSM.

Test Plan:
- Nominal build sequence:
  - Stimulus: start with hlit=29, hdist=29; cl_lens_ready; gen_done after 40 cycles; ll_lens_ready; two gen_done pulses.
  - Required response:
    - gen_inc pulses three times.
    - tree_num/bias sequence is 19/320, 286/0, 30/286.
    - One done pulse; all three valid flags =1.
- Illegal HLIT:
  - Stimulus: start with hlit=30.
  - Required response: err=1 on the next cycle, busy=1, no gen_inc. A following abort gives err=0, busy=0.
- Write-strobe routing:
  - Stimulus: toggle gen_winc during BUILD_LL, and also in WAIT_LL.
  - Required response: during BUILD_LL, only ll_we follows gen_winc, same cycle. In WAIT_LL, all *_we stay 0.
- Watchdog:
  - Stimulus: WDOG_CYCLES=16, and gen_done is never returned in BUILD_CL.
  - Required response: err=1 exactly 16 cycles after gen_inc; cl_valid stays 0.
- Abort during build:
  - Stimulus: abort asserted together with start in IDLE; separately, abort mid-BUILD_DIST followed by a late gen_done.
  - Required response:
    - start is ignored.
    - Mid-build abort gives IDLE with all valid=0.
    - The late gen_done causes no done pulse.
- Async reset:
  - Stimulus: rst_n low during BUILD_LL.
  - Required response: all outputs 0 immediately; after release, start is accepted normally.
